// File: rtl/adc_dsp_receiver.sv
// Codec ADC receiver for DSP-mode framing (LRP=1): oversamples BCLK, LRCLK and
// DATA on clk, deserialises a left/right word pair and hands it off with valid/ready.
module adc_dsp_receiver #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    BCLK,
    input  logic                    ADC_LR_CLK,
    input  logic                    ADC_DATA,
    output logic [SAMPLE_WIDTH-1:0] left_sample,
    output logic [SAMPLE_WIDTH-1:0] right_sample,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    frame_err
);

    localparam int CNT_W = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2
    } state_t;

    state_t                  state_r;
    logic [CNT_W-1:0]        bit_cnt_r;
    logic [SAMPLE_WIDTH-1:0] left_shift_r;
    logic [SAMPLE_WIDTH-2:0] right_shift_r;
    logic                    frame_err_r;

    logic [SYNC_STAGES-1:0]  bclk_sync_r;
    logic [SYNC_STAGES-1:0]  lr_sync_r;
    logic [SYNC_STAGES-1:0]  data_sync_r;
    logic                    bclk_d_r;
    logic                    lr_prev_r;

    logic [SAMPLE_WIDTH-1:0] left_sample_r;
    logic [SAMPLE_WIDTH-1:0] right_sample_r;
    logic                    out_valid_r;
    logic                    overrun_r;

    logic                    rise_s;
    logic                    lr_s;
    logic                    data_s;
    logic                    start_s;
    logic                    last_bit_s;
    logic                    frame_done_s;
    logic [SAMPLE_WIDTH-1:0] left_word_s;
    logic [SAMPLE_WIDTH-1:0] right_word_s;

    // Synchronizer chains for the three codec pins plus BCLK edge history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bclk_sync_r <= {SYNC_STAGES{1'b0}};
            lr_sync_r   <= {SYNC_STAGES{1'b0}};
            data_sync_r <= {SYNC_STAGES{1'b0}};
            bclk_d_r    <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], BCLK};
            lr_sync_r   <= {lr_sync_r[SYNC_STAGES-2:0], ADC_LR_CLK};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ADC_DATA};
            bclk_d_r    <= bclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Remembers the LRCLK level seen on the previous BCLK rise so only 0->1 markers start a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lr_prev_r <= 1'b0;
        end else if (rise_s) begin
            lr_prev_r <= lr_s;
        end else begin
            lr_prev_r <= lr_prev_r;
        end
    end

    // Bit-rise decode and the word values as they will stand after this bit.
    always_comb begin
        rise_s       = bclk_sync_r[SYNC_STAGES-1] & ~bclk_d_r;
        lr_s         = lr_sync_r[SYNC_STAGES-1];
        data_s       = data_sync_r[SYNC_STAGES-1];
        start_s      = rise_s & lr_s & ~lr_prev_r & enable;
        last_bit_s   = (bit_cnt_r == LAST_BIT);
        left_word_s  = {left_shift_r[SAMPLE_WIDTH-2:0], data_s};
        right_word_s = {right_shift_r, data_s};
        if ((state_r == RIGHT) && rise_s && !lr_s && last_bit_s && enable) begin
            frame_done_s = 1'b1;
        end else begin
            frame_done_s = 1'b0;
        end
    end

    // Frame state machine: tracks position in the frame and assembles both words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= WAIT_SYNC;
            bit_cnt_r     <= {CNT_W{1'b0}};
            left_shift_r  <= {SAMPLE_WIDTH{1'b0}};
            right_shift_r <= {(SAMPLE_WIDTH-1){1'b0}};
            frame_err_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            if (!enable) begin
                state_r       <= WAIT_SYNC;
                bit_cnt_r     <= {CNT_W{1'b0}};
                left_shift_r  <= {SAMPLE_WIDTH{1'b0}};
                right_shift_r <= {(SAMPLE_WIDTH-1){1'b0}};
            end else if (rise_s) begin
                case (state_r)
                    WAIT_SYNC: begin
                        if (start_s) begin
                            state_r       <= LEFT;
                            bit_cnt_r     <= CNT_W'(1);
                            left_shift_r  <= {{(SAMPLE_WIDTH-1){1'b0}}, data_s};
                            right_shift_r <= {(SAMPLE_WIDTH-1){1'b0}};
                        end
                    end
                    LEFT, RIGHT: begin
                        if (lr_s) begin
                            // Early marker: the frame was truncated, this bit is a fresh left MSB.
                            frame_err_r   <= 1'b1;
                            state_r       <= LEFT;
                            bit_cnt_r     <= CNT_W'(1);
                            left_shift_r  <= {{(SAMPLE_WIDTH-1){1'b0}}, data_s};
                            right_shift_r <= {(SAMPLE_WIDTH-1){1'b0}};
                        end else if (state_r == LEFT) begin
                            left_shift_r <= left_word_s;
                            if (last_bit_s) begin
                                state_r   <= RIGHT;
                                bit_cnt_r <= {CNT_W{1'b0}};
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end else begin
                            right_shift_r <= right_word_s[SAMPLE_WIDTH-2:0];
                            if (last_bit_s) begin
                                state_r   <= WAIT_SYNC;
                                bit_cnt_r <= {CNT_W{1'b0}};
                            end else begin
                                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_r   <= WAIT_SYNC;
                        bit_cnt_r <= {CNT_W{1'b0}};
                    end
                endcase
            end
        end
    end

    // Output holding registers with valid/ready handoff and overrun detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_sample_r  <= {SAMPLE_WIDTH{1'b0}};
            right_sample_r <= {SAMPLE_WIDTH{1'b0}};
            out_valid_r    <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (frame_done_s) begin
                if (!out_valid_r || out_ready) begin
                    left_sample_r  <= left_shift_r;
                    right_sample_r <= right_word_s;
                    out_valid_r    <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign left_sample  = left_sample_r;
    assign right_sample = right_sample_r;
    assign out_valid    = out_valid_r;
    assign overrun      = overrun_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_adc_dsp_receiver.sv
// Bench for adc_dsp_receiver: drives DSP-mode frames into a 16-bit and a 24-bit
// instance and compares against a frame-level handoff model.
`timescale 1ns/1ps
module tb_adc_dsp_receiver;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic reset, enable, BCLK, ADC_LR_CLK, ADC_DATA, out_ready;
    logic [15:0] l16, r16;
    logic        v16, ov16, fe16;
    logic [23:0] l24, r24;
    logic        v24, ov24, fe24;

    adc_dsp_receiver #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clk(clk), .reset(reset), .enable(enable), .BCLK(BCLK),
        .ADC_LR_CLK(ADC_LR_CLK), .ADC_DATA(ADC_DATA),
        .left_sample(l16), .right_sample(r16), .out_valid(v16),
        .out_ready(out_ready), .overrun(ov16), .frame_err(fe16));

    adc_dsp_receiver #(.SAMPLE_WIDTH(24), .SYNC_STAGES(2)) dut24 (
        .clk(clk), .reset(reset), .enable(enable), .BCLK(BCLK),
        .ADC_LR_CLK(ADC_LR_CLK), .ADC_DATA(ADC_DATA),
        .left_sample(l24), .right_sample(r24), .out_valid(v24),
        .out_ready(out_ready), .overrun(ov24), .frame_err(fe24));

    int checks = 0;
    int passed = 0;

    // Event counters: valid rising edges and pulse-high cycles.
    int vr16 = 0, ovc16 = 0, fec16 = 0, vr24 = 0, fec24 = 0;
    logic pv16 = 1'b0, pv24 = 1'b0;
    always @(negedge clk) begin
        if (v16 && !pv16) vr16 <= vr16 + 1;
        if (ov16)         ovc16 <= ovc16 + 1;
        if (fe16)         fec16 <= fec16 + 1;
        if (v24 && !pv24) vr24 <= vr24 + 1;
        if (fe24)         fec24 <= fec24 + 1;
        pv16 <= v16;
        pv24 <= v24;
    end

    task automatic bit_low(input logic lr, input logic d);
        @(negedge clk);
        BCLK = 1'b0; ADC_LR_CLK = lr; ADC_DATA = d;
        repeat (7) @(negedge clk);
    endtask

    task automatic bit_high();
        BCLK = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bit(input logic lr, input logic d);
        bit_low(lr, d);
        bit_high();
    endtask

    // Bit i of a frame: marker on bit 0, left word MSB first, then right word MSB first.
    function automatic logic [1:0] fbit(input int w, input logic [31:0] l, input logic [31:0] r, input int i);
        logic lr_b, d_b;
        lr_b = (i == 0);
        if (i < w) d_b = l[w-1-i];
        else       d_b = r[2*w-1-i];
        return {lr_b, d_b};
    endfunction

    task automatic send_bits(input int w, input logic [31:0] l, input logic [31:0] r, input int from, input int upto);
        logic [1:0] b;
        for (int i = from; i < upto; i++) begin
            b = fbit(w, l, r, i);
            send_bit(b[1], b[0]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0, 1'($urandom % 2));
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (l16 !== 16'h0)  $display("FAIL reset_l16: got %h want 0", l16);  else passed++;
        checks++; if (r16 !== 16'h0)  $display("FAIL reset_r16: got %h want 0", r16);  else passed++;
        checks++; if (v16 !== 1'b0)   $display("FAIL reset_v16: got %b want 0", v16);  else passed++;
        checks++; if (ov16 !== 1'b0)  $display("FAIL reset_ov16: got %b want 0", ov16); else passed++;
        checks++; if (fe16 !== 1'b0)  $display("FAIL reset_fe16: got %b want 0", fe16); else passed++;
        checks++; if (l24 !== 24'h0)  $display("FAIL reset_l24: got %h want 0", l24);  else passed++;
        checks++; if (r24 !== 24'h0)  $display("FAIL reset_r24: got %h want 0", r24);  else passed++;
        checks++; if (v24 !== 1'b0)   $display("FAIL reset_v24: got %b want 0", v24);  else passed++;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_basic();
        logic [1:0] b;
        int vv;
        vv = vr16;
        out_ready = 1'b1;
        send_bits(16, 32'hA5C3, 32'h0F0F, 0, 31);
        b = fbit(16, 32'hA5C3, 32'h0F0F, 31);
        bit_low(b[1], b[0]);
        BCLK = 1'b1;
        // Two sync stages, then the edge-detect cycle, then the output register.
        @(posedge clk); @(posedge clk); #1;
        checks++; if (v16 !== 1'b0) $display("FAIL basic_latency_early: got %b want 0", v16); else passed++;
        @(posedge clk); #1;
        checks++; if (v16 !== 1'b1) $display("FAIL basic_latency: got %b want 1", v16); else passed++;
        checks++; if (l16 !== 16'hA5C3) $display("FAIL basic_left: got %h want a5c3", l16); else passed++;
        checks++; if (r16 !== 16'h0F0F) $display("FAIL basic_right: got %h want 0f0f", r16); else passed++;
        @(posedge clk); #1;
        checks++; if (v16 !== 1'b0) $display("FAIL basic_valid_clear: got %b want 0", v16); else passed++;
        repeat (6) @(negedge clk);
        idle(2);
        checks++; if (vr16 - vv !== 1) $display("FAIL basic_pulses: got %0d want 1", vr16 - vv); else passed++;
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovc16;
        @(negedge clk); out_ready = 1'b0;
        send_bits(16, 32'hA5C3, 32'h0F0F, 0, 32);
        idle(2);
        checks++; if (v16 !== 1'b1) $display("FAIL ovr_first_valid: got %b want 1", v16); else passed++;
        send_bits(16, 32'h5A3C, 32'hF0F0, 0, 32);
        idle(2);
        checks++; if (ovc16 - o0 !== 1) $display("FAIL ovr_pulses: got %0d want 1", ovc16 - o0); else passed++;
        checks++; if (l16 !== 16'hA5C3) $display("FAIL ovr_left_held: got %h want a5c3", l16); else passed++;
        checks++; if (r16 !== 16'h0F0F) $display("FAIL ovr_right_held: got %h want 0f0f", r16); else passed++;
        @(negedge clk); out_ready = 1'b1; #1;
        checks++; if (v16 !== 1'b1) $display("FAIL ovr_valid_before_edge: got %b want 1", v16); else passed++;
        @(posedge clk); #1;
        checks++; if (v16 !== 1'b0) $display("FAIL ovr_valid_clear: got %b want 0", v16); else passed++;
        idle(1);
    endtask

    task automatic test_frame_err();
        int f0, vv;
        f0 = fec16; vv = vr16;
        send_bits(16, $urandom, $urandom, 0, 10);
        send_bits(16, 32'h1234, 32'h8001, 0, 32);
        idle(1);
        checks++; if (fec16 - f0 !== 1) $display("FAIL ferr_pulses: got %0d want 1", fec16 - f0); else passed++;
        checks++; if (vr16 - vv !== 1) $display("FAIL ferr_valids: got %0d want 1", vr16 - vv); else passed++;
        checks++; if (l16 !== 16'h1234) $display("FAIL ferr_left: got %h want 1234", l16); else passed++;
        checks++; if (r16 !== 16'h8001) $display("FAIL ferr_right: got %h want 8001", r16); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] b;
        logic [31:0] la, ra;
        int f0, vv;
        la = $urandom; ra = $urandom;
        send_bits(16, la, ra, 0, 20);
        b = fbit(16, la, ra, 20);
        bit_low(b[1], b[0]);
        @(negedge clk); #3 reset = 1'b1; #1;
        checks++; if (l16 !== 16'h0) $display("FAIL rstmid_left: got %h want 0", l16); else passed++;
        checks++; if (r16 !== 16'h0) $display("FAIL rstmid_right: got %h want 0", r16); else passed++;
        checks++; if ({v16, ov16, fe16} !== 3'b000) $display("FAIL rstmid_flags: got %b want 000", {v16, ov16, fe16}); else passed++;
        repeat (3) @(negedge clk); reset = 1'b0;
        f0 = fec16; vv = vr16;
        bit_high();
        send_bits(16, la, ra, 21, 32);
        send_bits(16, 32'h7FFF, 32'h8000, 0, 32);
        idle(1);
        checks++; if (vr16 - vv !== 1) $display("FAIL rstmid_valids: got %0d want 1", vr16 - vv); else passed++;
        checks++; if (fec16 - f0 !== 0) $display("FAIL rstmid_ferr: got %0d want 0", fec16 - f0); else passed++;
        checks++; if (l16 !== 16'h7FFF) $display("FAIL rstmid_new_left: got %h want 7fff", l16); else passed++;
        checks++; if (r16 !== 16'h8000) $display("FAIL rstmid_new_right: got %h want 8000", r16); else passed++;
    endtask

    task automatic test_enable();
        logic [31:0] la, ra;
        int f0, vv;
        la = $urandom; ra = $urandom;
        f0 = fec16; vv = vr16;
        send_bits(16, la, ra, 0, 6);
        @(negedge clk); enable = 1'b0;
        send_bits(16, la, ra, 6, 10);
        checks++; if (l16 !== 16'h7FFF) $display("FAIL en_left_held: got %h want 7fff", l16); else passed++;
        checks++; if (r16 !== 16'h8000) $display("FAIL en_right_held: got %h want 8000", r16); else passed++;
        @(negedge clk); enable = 1'b1;
        send_bits(16, la, ra, 10, 32);
        send_bits(16, 32'h00FF, 32'hFF00, 0, 32);
        idle(1);
        checks++; if (fec16 - f0 !== 0) $display("FAIL en_ferr: got %0d want 0", fec16 - f0); else passed++;
        checks++; if (vr16 - vv !== 1) $display("FAIL en_valids: got %0d want 1", vr16 - vv); else passed++;
        checks++; if (l16 !== 16'h00FF) $display("FAIL en_left: got %h want 00ff", l16); else passed++;
        checks++; if (r16 !== 16'hFF00) $display("FAIL en_right: got %h want ff00", r16); else passed++;
    endtask

    task automatic test_w24();
        int vv;
        pulse_reset();
        out_ready = 1'b1;
        idle(1);
        vv = vr24;
        send_bits(24, 32'h800001, 32'h7FFFFE, 0, 47);
        checks++; if (vr24 - vv !== 0) $display("FAIL w24_early: got %0d valids want 0", vr24 - vv); else passed++;
        send_bits(24, 32'h800001, 32'h7FFFFE, 47, 48);
        checks++; if (vr24 - vv !== 1) $display("FAIL w24_valids: got %0d want 1", vr24 - vv); else passed++;
        checks++; if (l24 !== 24'h800001) $display("FAIL w24_left: got %h want 800001", l24); else passed++;
        checks++; if (r24 !== 24'h7FFFFE) $display("FAIL w24_right: got %h want 7ffffe", r24); else passed++;
        idle(1);
    endtask

    // Random frames, random ready and random truncated prefixes against a pair-level model.
    task automatic test_random();
        logic        mv, rdy;
        logic [15:0] ml, mr, nl, nr;
        int          mov, mfe, ov0, fe0, k;
        pulse_reset();
        idle(1);
        mv = 1'b0; ml = 16'h0; mr = 16'h0; mov = 0; mfe = 0;
        ov0 = ovc16; fe0 = fec16;
        for (int it = 0; it < 10; it++) begin
            @(negedge clk);
            rdy = 1'($urandom % 2);
            out_ready = rdy;
            if (rdy) mv = 1'b0;
            if ($urandom % 3 == 0) begin
                k = $urandom_range(2, 31);
                send_bits(16, $urandom, $urandom, 0, k);
                mfe++;
            end
            nl = 16'($urandom); nr = 16'($urandom);
            send_bits(16, {16'h0, nl}, {16'h0, nr}, 0, 32);
            if (!mv || rdy) begin ml = nl; mr = nr; mv = 1'b1; end
            else mov++;
            if (rdy) mv = 1'b0;
            idle(2);
            checks++; if (l16 !== ml) $display("FAIL rnd%0d_left: got %h want %h", it, l16, ml); else passed++;
            checks++; if (r16 !== mr) $display("FAIL rnd%0d_right: got %h want %h", it, r16, mr); else passed++;
            checks++; if (v16 !== mv) $display("FAIL rnd%0d_valid: got %b want %b", it, v16, mv); else passed++;
            checks++; if (ovc16 - ov0 !== mov) $display("FAIL rnd%0d_overrun: got %0d want %0d", it, ovc16 - ov0, mov); else passed++;
            checks++; if (fec16 - fe0 !== mfe) $display("FAIL rnd%0d_ferr: got %0d want %0d", it, fec16 - fe0, mfe); else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        BCLK = 1'b0; ADC_LR_CLK = 1'b0; ADC_DATA = 1'b0;
        test_reset();
        test_basic();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        test_enable();
        test_w24();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adc_dsp_receiver.md
ADC_DSP_RECEIVER -- requirements
Module: adc_dsp_receiver

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, bits per channel word; legal values 16, 20, 24.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for BCLK, ADC_LR_CLK and ADC_DATA; minimum 2.
REQ-003 clk  input  1  system clock; the only clock, with all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  capture enable.
REQ-006 BCLK  input  1  codec bit clock, treated as data and sampled on clk.
REQ-007 ADC_LR_CLK  input  1  codec ADC frame marker, DSP mode with LRP=1, codec as slave.
REQ-008 ADC_DATA  input  1  codec serial ADC data, MSB first.
REQ-009 left_sample  output  SAMPLE_WIDTH  captured left word.
REQ-010 right_sample  output  SAMPLE_WIDTH  captured right word.
REQ-011 out_valid  output  1  sample pair available.
REQ-012 out_ready  input  1  consumer accepts the pair.
REQ-013 overrun  output  1  one-cycle pulse when a completed frame is dropped.
REQ-014 frame_err  output  1  one-cycle pulse when a frame is truncated.

Function
REQ-015 Input synchronization:
- BCLK, ADC_LR_CLK and ADC_DATA SHALL each pass through SYNC_STAGES flops.
- A BCLK rise SHALL be detected in the clk cycle where the synced BCLK is 1 and its one-cycle-delayed copy is 0.
REQ-016 On each detected BCLK rise, the synced ADC_LR_CLK and ADC_DATA SHALL be sampled together; no other cycle samples them.
REQ-017 Frame format:
- A marker is ADC_LR_CLK sampled 1.
- The ADC_DATA sampled on the same BCLK rise as the marker is the left MSB.
- Then SAMPLE_WIDTH-1 further left bits follow, then SAMPLE_WIDTH right bits, MSB first, each on the next BCLK rise.
REQ-018 State machine SHALL have the states WAIT_SYNC, LEFT and RIGHT.
REQ-019 WAIT_SYNC SHALL go to LEFT on a marker while enable=1, storing the MSB and setting the bit counter to 1.
REQ-020 LEFT SHALL go to RIGHT after the SAMPLE_WIDTH-th left bit. RIGHT SHALL go to WAIT_SYNC after the SAMPLE_WIDTH-th right bit, and that frame is complete.
REQ-021 A marker sampled in LEFT or RIGHT before the frame completes SHALL:
- pulse frame_err for one cycle;
- discard the partial words;
- restart LEFT using that bit as the new left MSB.
REQ-022 When enable=0, the FSM SHALL enter WAIT_SYNC on the next clk and discard partial data without asserting frame_err. Already-held output data SHALL be unaffected.
REQ-023 ADC_LR_CLK high on BCLK rises after the frame completes but before the next marker SHALL be ignored. Only a 0-to-1 marker sampled in WAIT_SYNC starts a frame.
REQ-024 On frame completion, if out_valid=0, or out_valid=1 with out_ready=1 in the same cycle:
- left_sample and right_sample SHALL load the new words on the next clk;
- out_valid SHALL be 1 on that clk.
REQ-025 On frame completion with out_valid=1 and out_ready=0:
- the new frame SHALL be dropped;
- overrun SHALL pulse for one cycle;
- the held outputs SHALL be unchanged.
REQ-026 out_valid SHALL stay high with stable data until a cycle with out_ready=1, then clear on the next clk unless REQ-024 reloads it.
REQ-027 Latency: out_valid SHALL rise exactly 1 clk after the cycle in which the last right-bit BCLK rise is detected.
REQ-028 Correct operation SHALL require clk frequency of at least 4x the BCLK frequency; behavior is unspecified below this.

Reset
REQ-029 While reset=1, the following SHALL be forced immediately, independent of clk:
- state=WAIT_SYNC, bit counter=0;
- left_sample=0, right_sample=0;
- out_valid=0, overrun=0, frame_err=0;
- all synchronizer flops=0.
REQ-030 After a mid-frame reset, the partial frame SHALL be lost and capture SHALL resume only at the next marker after reset deasserts.

Verification
REQ-031 SAMPLE_WIDTH=16, clk 50 MHz, BCLK 3.072 MHz, enable=1, out_ready=1, one frame of L=0xA5C3, R=0x0F0F -> one out_valid pulse; left_sample=0xA5C3, right_sample=0x0F0F; out_valid 1 clk after the last-bit edge detect.
REQ-032 Two consecutive frames with out_ready=0 -> first pair held, overrun pulses once at the second completion, outputs stay 0xA5C3/0x0F0F; then out_ready=1 -> out_valid clears next clk.
REQ-033 Marker re-asserted after 10 left bits, then a full frame L=0x1234, R=0x8001 -> frame_err pulses once; next out pair is 0x1234/0x8001.
REQ-034 reset pulsed during right bit 5 -> all outputs 0 asynchronously; the following full frame L=0x7FFF, R=0x8000 is captured correctly.
REQ-035 enable dropped mid-left-word, then re-raised before a new frame L=0x00FF, R=0xFF00 -> no frame_err, no out_valid for the aborted frame; next pair is 0x00FF/0xFF00.
REQ-036 SAMPLE_WIDTH=24, frame L=0x800001, R=0x7FFFFE -> exact capture; completion is detected after 48 bits.
